// File: rtl/membrane_potential_unit.sv
// Membrane potential unit: sums NUM_ROWS psums per neuron, integrates into
// a per-neuron potential store, fires against THRESHOLD with subtractive reset.
module membrane_potential_unit #(
    parameter int PSUM_W        = 12,
    parameter int MP_W          = 14,
    parameter int NUM_ROWS      = 3,
    parameter int NUM_NEURONS   = 25,
    parameter int NUM_TIMESTEPS = 2,
    parameter int THRESHOLD     = 64,
    localparam int AW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
    localparam int TW = (NUM_TIMESTEPS > 1) ? $clog2(NUM_TIMESTEPS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PSUM_W-1:0] in_psum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_spike,
    output logic [AW-1:0]     out_addr,
    output logic [TW-1:0]     out_ts,
    output logic [MP_W-1:0]   out_potential,
    output logic              done
);

    localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    typedef enum logic [1:0] {
        S_ACC,
        S_FIRE,
        S_OUT
    } state_t;

    state_t            state_q;
    logic [MP_W-1:0]   acc_q;
    logic [RW-1:0]     row_q;
    logic [AW-1:0]     idx_q;
    logic [TW-1:0]     ts_q;
    logic [MP_W-1:0]   mem_q [NUM_NEURONS];

    logic              out_valid_q;
    logic              out_spike_q;
    logic [AW-1:0]     out_addr_q;
    logic [TW-1:0]     out_ts_q;
    logic [MP_W-1:0]   out_pot_q;
    logic              done_q;

    logic [MP_W:0]     mp_sum;
    logic [MP_W-1:0]   mp_sat;
    logic              fire;
    logic [MP_W-1:0]   mp_new;
    logic              last_idx;
    logic              last_ts;

    assign in_ready      = rst_n & (state_q == S_ACC);
    assign out_valid     = out_valid_q;
    assign out_spike     = out_spike_q;
    assign out_addr      = out_addr_q;
    assign out_ts        = out_ts_q;
    assign out_potential = out_pot_q;
    assign done          = done_q;

    assign last_idx = (idx_q == AW'(NUM_NEURONS - 1));
    assign last_ts  = (ts_q == TW'(NUM_TIMESTEPS - 1));

    // Integrate: one extra bit catches overflow, clamp before threshold compare
    always_comb begin
        mp_sum = {1'b0, mem_q[idx_q]} + {1'b0, acc_q};
        mp_sat = mp_sum[MP_W] ? {MP_W{1'b1}} : mp_sum[MP_W-1:0];
        fire   = (mp_sat >= MP_W'(THRESHOLD));
        mp_new = fire ? (mp_sat - MP_W'(THRESHOLD)) : mp_sat;
    end

    // Control FSM, potential store and registered result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_ACC;
            acc_q       <= '0;
            row_q       <= '0;
            idx_q       <= '0;
            ts_q        <= '0;
            out_valid_q <= 1'b0;
            out_spike_q <= 1'b0;
            out_addr_q  <= '0;
            out_ts_q    <= '0;
            out_pot_q   <= '0;
            done_q      <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_ACC: begin
                    if (in_valid) begin
                        acc_q <= acc_q + MP_W'(in_psum);
                        if (row_q == RW'(NUM_ROWS - 1)) begin
                            row_q   <= '0;
                            state_q <= S_FIRE;
                        end else begin
                            row_q <= row_q + 1'b1;
                        end
                    end
                end
                S_FIRE: begin
                    mem_q[idx_q] <= mp_new;
                    out_spike_q  <= fire;
                    out_addr_q   <= idx_q;
                    out_ts_q     <= ts_q;
                    out_pot_q    <= mp_new;
                    out_valid_q  <= 1'b1;
                    acc_q        <= '0;
                    state_q      <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_ACC;
                        if (last_idx) begin
                            idx_q <= '0;
                            if (last_ts) begin
                                ts_q   <= '0;
                                done_q <= 1'b1;
                                for (int i = 0; i < NUM_NEURONS; i++) begin
                                    mem_q[i] <= '0;
                                end
                            end else begin
                                ts_q <= ts_q + 1'b1;
                            end
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_membrane_potential_unit.sv
// Directed bench for membrane_potential_unit: table of per-neuron vectors
// plus hand-written backpressure and mid-accumulation reset sequences.
module tb_membrane_potential_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_psum;
    logic        out_valid;
    logic        out_ready;
    logic        out_spike;
    logic [4:0]  out_addr;
    logic [0:0]  out_ts;
    logic [13:0] out_potential;
    logic        done;

    int checks = 0;
    int errors = 0;

    membrane_potential_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_psum       (in_psum),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_spike     (out_spike),
        .out_addr      (out_addr),
        .out_ts        (out_ts),
        .out_potential (out_potential),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   p0;
        int   p1;
        int   p2;
        logic spk;
        int   addr;
        int   ts;
        int   pot;
        logic dn;
    } vec_t;

    vec_t tbl [100];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Feed three psums, wait for the result, optionally stall, then handshake.
    task automatic do_neuron(input int p0, input int p1, input int p2,
                             input logic spk, input int addr, input int ts,
                             input int pot, input int hold);
        int q [3];
        int n;
        q[0] = p0;
        q[1] = p1;
        q[2] = p2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("in_ready_acc", int'(in_ready), 1);
            in_valid = 1'b1;
            in_psum  = 12'(q[i]);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("fire_out_valid", int'(out_valid), 0);
        chk("fire_in_ready", int'(in_ready), 0);
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            errors++;
            checks++;
            $display("FAIL out_valid_timeout: got 0 expected 1");
            return;
        end
        chk("latency", n, 1);
        chk("spike", int'(out_spike), int'(spk));
        chk("addr", int'(out_addr), addr);
        chk("ts", int'(out_ts), ts);
        chk("potential", int'(out_potential), pot);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_psum   = 12'd999;
            @(negedge clk);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_potential", int'(out_potential), pot);
            chk("bp_spike", int'(out_spike), int'(spk));
            chk("bp_addr", int'(out_addr), addr);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_out_valid", int'(out_valid), 0);
        chk("post_in_ready", int'(in_ready), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 100; k++) begin
            tbl[k].p0   = 0;
            tbl[k].p1   = 0;
            tbl[k].p2   = 0;
            tbl[k].spk  = 1'b0;
            tbl[k].addr = k % 25;
            tbl[k].ts   = (k % 50) / 25;
            tbl[k].pot  = 0;
            tbl[k].dn   = ((k % 50) == 49);
        end
        tbl[0]  = '{10, 20, 30, 1'b0, 0, 0, 60, 1'b0};
        tbl[25] = '{1, 2, 1, 1'b1, 0, 1, 0, 1'b0};
        tbl[50] = '{4095, 4095, 4095, 1'b1, 0, 0, 12221, 1'b0};
        tbl[75] = '{4095, 4095, 4095, 1'b1, 0, 1, 16319, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_psum   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_addr", int'(out_addr), 0);
        chk("rst_ts", int'(out_ts), 0);
        chk("rst_potential", int'(out_potential), 0);
        chk("rst_spike", int'(out_spike), 0);
        rst_n = 1'b1;
        #1;
        chk("rst_release_in_ready", int'(in_ready), 1);

        for (int k = 0; k < 100; k++) begin
            do_neuron(tbl[k].p0, tbl[k].p1, tbl[k].p2, tbl[k].spk,
                      tbl[k].addr, tbl[k].ts, tbl[k].pot, 0);
            chk("done", int'(done), int'(tbl[k].dn));
        end
        @(negedge clk);
        chk("done_one_cycle", int'(done), 0);

        do_neuron(1, 1, 1, 1'b0, 0, 0, 3, 0);
        do_neuron(50, 10, 4, 1'b1, 1, 0, 0, 5);
        do_neuron(5, 5, 5, 1'b0, 2, 0, 15, 0);

        @(negedge clk);
        in_valid = 1'b1;
        in_psum  = 12'd100;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        do_neuron(5, 5, 5, 1'b0, 0, 0, 15, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/membrane_potential_unit.md
# membrane_potential_unit

Downstream stage of the PE function unit in the spiking convolution datapath. It consumes the 12-bit partial sums the function unit emits and sums NUM_ROWS of them into one output-neuron contribution. It adds that contribution to the neuron's stored membrane potential, compares the result against THRESHOLD and emits one spike decision per neuron per timestep. It stores one potential per output neuron across all timesteps of an image and clears the store at image end.

## Interface
- PSUM_W, 12, width of an incoming partial sum.
- MP_W, 14, width of a stored membrane potential; arithmetic saturates at 2^MP_W-1.
- NUM_ROWS, 3, partial sums per neuron per timestep.
- NUM_NEURONS, 25, output neurons per timestep; stored in an internal register array.
- NUM_TIMESTEPS, 2, timesteps per image.
- THRESHOLD, 64, firing threshold.
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  in_psum is valid.
- in_ready  out  1  block accepts a psum this cycle.
- in_psum  in  PSUM_W  unsigned partial sum.
- out_valid  out  1  spike result is valid.
- out_ready  in  1  consumer accepts the result.
- out_spike  out  1  1 = neuron fired.
- out_addr  out  $clog2(NUM_NEURONS)  neuron index of the result.
- out_ts  out  $clog2(NUM_TIMESTEPS)  timestep of the result; minimum width 1.
- out_potential  out  MP_W  potential written back to the neuron's store.
- done  out  1  one-cycle pulse at image completion.

## Operation
- Reset (rst_n low at an edge): state=ACC, acc=0, row_cnt=0, idx=0, ts=0, all stored potentials=0, out_valid=0, out_spike=0, out_addr=0, out_ts=0, out_potential=0, done=0.
- in_ready = rst_n & (state==ACC). It is combinational.
- ACC: each handshake (in_valid & in_ready) sets acc += in_psum and row_cnt++.
  - On the NUM_ROWS-th handshake, row_cnt returns to 0 and the state goes to FIRE.
  - acc needs no saturation: the maximum, NUM_ROWS*(2^PSUM_W-1) = 12285, fits in MP_W.
- FIRE (1 cycle): mp = mem[idx] + acc, computed in MP_W+1 bits and saturated to 2^MP_W-1.
  - If mp >= THRESHOLD: spike=1 and mem[idx] <= mp - THRESHOLD (subtractive reset).
  - Otherwise spike=0 and mem[idx] <= mp.
  - out_spike, out_addr=idx, out_ts=ts and out_potential=new mem value are registered. out_valid <= 1, acc <= 0, and the state goes to OUT.
- OUT: all outputs are held stable while out_valid & !out_ready. On the out_valid & out_ready edge:
  - out_valid <= 0 and the state goes to ACC.
  - idx++. When idx wraps from NUM_NEURONS-1 to 0, ts++.
  - If idx==NUM_NEURONS-1 and ts==NUM_TIMESTEPS-1: idx=0, ts=0, every mem entry=0, and done <= 1 for exactly the next cycle.
- done is 0 in every other cycle.
- Neurons are processed strictly in index order. Psums arrive grouped: NUM_ROWS consecutive psums per neuron.

## Timing
- Input throughput: 1 psum/cycle while in ACC.
- Latency: the NUM_ROWS-th psum is accepted at edge E. FIRE runs in cycle E..E+1. out_valid is high from edge E+1.
- in_ready is 0 from the final-psum edge until the edge that completes the output handshake. There is no overlap between output and the next neuron's input.
- Minimum neuron period with out_ready held high: NUM_ROWS+2 cycles.
- Backpressure: out_valid, once high, stays high with constant payload until out_ready. out_valid never depends combinationally on out_ready.
- Reset mid-operation: a partial acc, a pending FIRE or an un-accepted output is discarded. The first psum after reset belongs to neuron 0, timestep 0.
- Saturation: an mp that exceeds 16383 is clamped before the threshold compare.
- in_valid asserted outside ACC is ignored; no psum is consumed.

## Test plan
- Basic: after reset, psums 10,20,30 with out_ready=1.
  - out_valid is asserted 1 cycle after the 3rd accept.
  - out_spike=0, out_addr=0, out_ts=0, out_potential=60.
- Fire across timesteps: as basic, then 24 neurons of zeros, then neuron 0 at ts1 gets psums 1,2,1.
  - mp=64, so out_spike=1, out_ts=1, out_potential=0.
- Saturation: neuron 0 gets 4095,4095,4095 in both timesteps (other neurons get 0).
  - ts0: spike=1, out_potential=12221.
  - ts1: mp clamps to 16383, spike=1, out_potential=16319.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises.
  - out_valid stays 1, payload is unchanged, in_ready=0, and extra in_valid pulses are not consumed.
  - Release out_ready: one handshake, then in_ready=1 the next cycle.
- Reset mid-accumulation: feed psums 100,100, drive rst_n=0 for one edge, then feed 5,5,5.
  - Result: out_addr=0, out_ts=0, out_potential=15, spike=0.
- Image end: complete 2x25 outputs.
  - done is high for exactly one cycle after the last handshake.
  - Next image, neuron 0 with psums 1,1,1 gives out_potential=3 and out_ts=0, proving the store was cleared.
